// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial processor datapath and decoder.
package serial_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [2:0] {
    RPASS = 3'd0,
    RADD  = 3'd1,
    RSUB  = 3'd2,
    RAND  = 3'd3,
    ROR   = 3'd4,
    RXOR  = 3'd5
  } alu_func_t;

endpackage

// File: rtl/serial_alu_bit.sv
// One-bit ALU slice: combinational result and carry-out for a single bit position.
module serial_alu_bit
  import serial_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [2:0] func,
  output logic       r,
  output logic       cout
);

  logic b_eff;

  always_comb begin
    r     = a;
    cout  = 1'b0;
    b_eff = (func == RSUB) ? ~b : b;
    case (func)
      RPASS: r = b;
      RADD, RSUB: begin
        r    = a ^ b_eff ^ cin;
        cout = (a & b_eff) | (cin & (a ^ b_eff));
      end
      RAND:    r = a & b;
      ROR:     r = a | b;
      RXOR:    r = a ^ b;
      // Reserved codes pass A through, leaving the accumulator intact over a word.
      default: r = a;
    endcase
  end

endmodule

// File: rtl/serial_datapath.sv
// Bit-serial execution datapath: LSB-first accumulator/operand processing with flag commit.
module serial_datapath
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_a,
  input  logic             load_b,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift,
  input  logic [2:0]       alu_func,
  input  logic             write,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] opr,
  output logic             last_bit,
  output logic             carry_flag,
  output logic             zero_flag
);

  localparam int unsigned IdxW = $clog2(WIDTH);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WIDTH - 1);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opr_q, opr_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             nz_q, nz_d;
  logic             carry_flag_q, carry_flag_d;
  logic             zero_flag_q, zero_flag_d;

  logic bit0;
  logic cin;
  logic r;
  logic cout;
  logic do_load;
  logic do_shift;
  logic carry_s;
  logic nz_s;

  assign bit0     = (idx_q == '0);
  assign cin      = bit0 ? (alu_func == RSUB) : carry_q;
  assign do_load  = load_a | load_b;
  assign do_shift = shift & ~do_load;

  serial_alu_bit u_alu (
    .a    (acc_q[0]),
    .b    (opr_q[0]),
    .cin  (cin),
    .func (alu_func),
    .r    (r),
    .cout (cout)
  );

  always_comb begin
    acc_d        = acc_q;
    opr_d        = opr_q;
    idx_d        = idx_q;
    carry_d      = carry_q;
    nz_d         = nz_q;
    carry_flag_d = carry_flag_q;
    zero_flag_d  = zero_flag_q;

    // State after this cycle's shift (if any); a load cycle commits pre-load state.
    carry_s = carry_q;
    nz_s    = nz_q;
    if (do_shift) begin
      carry_s = cout;
      nz_s    = bit0 ? r : (nz_q | r);
    end

    if (do_load) begin
      if (load_a) acc_d = load_data;
      if (load_b) opr_d = load_data;
      idx_d   = '0;
      carry_d = 1'b0;
      nz_d    = 1'b0;
    end else if (do_shift) begin
      acc_d   = {r, acc_q[WIDTH-1:1]};
      opr_d   = {opr_q[0], opr_q[WIDTH-1:1]};
      idx_d   = (idx_q == LastIdx) ? '0 : idx_q + IdxW'(1);
      carry_d = carry_s;
      nz_d    = nz_s;
    end

    if (write) begin
      carry_flag_d = carry_s;
      zero_flag_d  = ~nz_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q        <= '0;
      opr_q        <= '0;
      idx_q        <= '0;
      carry_q      <= 1'b0;
      nz_q         <= 1'b0;
      carry_flag_q <= 1'b0;
      zero_flag_q  <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      opr_q        <= opr_d;
      idx_q        <= idx_d;
      carry_q      <= carry_d;
      nz_q         <= nz_d;
      carry_flag_q <= carry_flag_d;
      zero_flag_q  <= zero_flag_d;
    end
  end

  assign acc        = acc_q;
  assign opr        = opr_q;
  assign last_bit   = shift & ~rst & (idx_q == LastIdx);
  assign carry_flag = carry_flag_q;
  assign zero_flag  = zero_flag_q;

endmodule
